mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_if.sv | 25 ++
 rtl/mul_div_unit.sv | 181 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Request/response bundle for the iterative multiply/divide unit.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, src1, src2, cancel, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, src1, src2, cancel, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, sharing one shift register, fixed WIDTH-cycle latency.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic      clk,
  input  logic      reset,
  mul_div_if.slave  bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;
  localparam logic [2:0] OP_MODU  = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             is_signed;
  logic             in_signed;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] iter_acc;
  logic [WIDTH-1:0] iter_sh;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] final_res;
  logic             accept;

  // One datapath iteration plus sign/corner-case fix-up of the final value.
  always_comb begin
    is_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_MOD);
    in_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
    src1_mag  = (in_signed && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
    src2_mag  = (in_signed && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;

    mul_sum   = {1'b0, acc_q} + {1'b0, (sh_q[0] ? opnd_q : '0)};
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};

    if (op_q[2]) begin
      // Borrow out of the trial subtraction means the divisor did not fit.
      iter_acc = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      iter_sh  = {sh_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      iter_acc = mul_sum[WIDTH:1];
      iter_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end

    prod     = {iter_acc, iter_sh};
    prod_fix = (is_signed && (src1_q[WIDTH-1] ^ src2_q[WIDTH-1])) ? -prod : prod;

    quot = iter_sh;
    rem  = iter_acc;
    if (is_signed && (src1_q[WIDTH-1] ^ src2_q[WIDTH-1])) quot = -quot;
    if (is_signed && src1_q[WIDTH-1])                     rem  = -rem;
    if (src2_q == '0) begin
      quot = '1;
      rem  = src1_q;
    end

    case (op_q)
      OP_MULH, OP_MULHU: final_res = prod_fix[W2-1:WIDTH];
      OP_DIV,  OP_DIVU:  final_res = quot;
      OP_MOD,  OP_MODU:  final_res = rem;
      default:           final_res = prod_fix[WIDTH-1:0];
    endcase
  end

  assign accept = bus.in_valid && in_ready_q && !bus.cancel;

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    result_d = (state_q == DONE) ? result_q : '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = bus.op;
          src1_d  = bus.src1;
          src2_d  = bus.src2;
          acc_d   = '0;
          sh_d    = src1_mag;
          opnd_d  = src2_mag;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = iter_acc;
          sh_d  = iter_sh;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = final_res;
          end
        end
      end
      DONE: begin
        if (bus.cancel || bus.out_ready) begin
          state_d  = IDLE;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      opnd_q      <= opnd_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32 with hand-computed expectations.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the result, check latency and value, then drain.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin step(); n++; end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src1     = a;
    bus.src2     = b;
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 200) begin step(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'd32);
    chk(tag, bus.result, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] held;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_result",    bus.result,         32'd0);
    reset = 1'b0;
    step();

    do_op("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh",    3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_op("mulhu",   3'd2, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006);
    do_op("mul_rsv", 3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mul_m1",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op("mulh_mn", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_m", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("div",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    do_op("mod",     3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    do_op("divu",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
    do_op("modu",    3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001);
    do_op("div_z",   3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    do_op("mod_z",   3'd5, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    do_op("divu_z",  3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF);
    do_op("modu_z",  3'd7, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("mod_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Backpressure: hold the result for 10 cycles.
    bus.in_valid = 1'b1;
    bus.op       = 3'd6;
    bus.src1     = 32'd1000;
    bus.src2     = 32'd3;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin step(); n++; end
    chk("bp_lat", 32'(n), 32'd32);
    held = bus.result;
    chk("bp_val", held, 32'd333);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), bus.result, 32'd333);
      chk($sformatf("bp_nrdy%0d", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_vld%0d", i), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_rdy", 32'(bus.in_ready), 32'd1);
    chk("bp_res0", bus.result, 32'd0);
    do_op("b2b_modu", 3'd7, 32'd1000, 32'd3, 32'd1);

    // Cancel sampled at the fifth edge after accept.
    bus.in_valid = 1'b1;
    bus.op       = 3'd4;
    bus.src1     = 32'd50;
    bus.src2     = 32'd5;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk("cxl_busy",  32'(bus.busy),      32'd0);
    chk("cxl_rdy",   32'(bus.in_ready),  32'd1);
    chk("cxl_vld",   32'(bus.out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("cxl_no_vld", 32'(seen), 32'd0);
    do_op("cxl_divu", 3'd6, 32'd100, 32'd7, 32'h0000_000E);

    // Reset sampled at the tenth edge after accept.
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.src1     = 32'd9;
    bus.src2     = 32'd9;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_rdy",  32'(bus.in_ready),  32'd1);
    chk("mrst_vld",  32'(bus.out_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy),      32'd0);
    chk("mrst_res",  bus.result,         32'd0);

    // Cancel and a valid request on the same edge in IDLE.
    bus.in_valid = 1'b1;
    bus.cancel   = 1'b1;
    bus.op       = 3'd0;
    bus.src1     = 32'd3;
    bus.src2     = 32'd4;
    step();
    bus.in_valid = 1'b0;
    bus.cancel   = 1'b0;
    chk("cxacc_busy", 32'(bus.busy),     32'd0);
    chk("cxacc_rdy",  32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("mrst_no_vld", 32'(seen), 32'd0);
    do_op("post_mul", 3'd0, 32'd12, 32'd11, 32'd132);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
